// File: rtl/sort_xcel_drain.sv
// sort_xcel_drain: snapshots the sort-cell outputs on a start handshake and
// streams the occupied cells out in cell order (cell 0 first) on a val/rdy
// port. It pulses done when the stream ends.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start_val / start_rdy      start handshake
//   cells, count               packed cell values and occupied-cell count,
//                              both sampled only on start acceptance
//   out_val / out_rdy          output stream handshake
//   out_data, out_idx, out_last  current element, its index, final marker
//   done                       one-cycle pulse when the drain completes
//   order_err                  sticky flag, set when a descending pair is drained
//
// Optional feature: define SORT_XCEL_DRAIN_CHECK_EN to build the order checker.
// When the macro is undefined, order_err is tied to 0.

module sort_xcel_drain #(
   parameter int unsigned NBITS  = 32,
   parameter int unsigned NCELLS = 8,
   parameter int unsigned CBITS  = $clog2(NCELLS + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start_val,
   output logic                    start_rdy,
   input  logic [NCELLS*NBITS-1:0] cells,
   input  logic [CBITS-1:0]        count,
   output logic                    out_val,
   input  logic                    out_rdy,
   output logic [NBITS-1:0]        out_data,
   output logic [CBITS-1:0]        out_idx,
   output logic                    out_last,
   output logic                    done,
   output logic                    order_err
);

   localparam int unsigned IBITS = $clog2(NCELLS);

   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_DONE} state_e;

   state_e            state_q, state_d;
   logic [NBITS-1:0]  snap_q [NCELLS];
   logic [NBITS-1:0]  snap_d [NCELLS];
   logic [CBITS-1:0]  eff_q, eff_d;
   logic [CBITS-1:0]  idx_q, idx_d;

   logic              accept;
   logic              xfer;
   logic              is_last;
   logic [CBITS-1:0]  eff_clamp;
   logic [NBITS-1:0]  cur_data;

   // Element under the read pointer; idx never exceeds NCELLS-1, so the low bits suffice.
   assign cur_data  = snap_q[idx_q[IBITS-1:0]];
   assign is_last   = (idx_q == (eff_q - CBITS'(1)));
   assign eff_clamp = (count > CBITS'(NCELLS)) ? CBITS'(NCELLS) : count;
   assign accept    = (state_q == S_IDLE) && start_val;
   assign xfer      = (state_q == S_DRAIN) && out_rdy;

   // Next-state and output decode; every output depends on registered state only.
   always_comb begin
      state_d   = state_q;
      snap_d    = snap_q;
      eff_d     = eff_q;
      idx_d     = idx_q;
      start_rdy = 1'b0;
      out_val   = 1'b0;
      out_data  = '0;
      out_idx   = '0;
      out_last  = 1'b0;
      done      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            start_rdy = 1'b1;
            if (accept) begin
               for (int i = 0; i < int'(NCELLS); i++) begin
                  snap_d[i] = cells[i*NBITS +: NBITS];
               end
               eff_d   = eff_clamp;
               idx_d   = '0;
               state_d = (eff_clamp != '0) ? S_DRAIN : S_DONE;
            end
         end
         S_DRAIN: begin
            out_val  = 1'b1;
            out_data = cur_data;
            out_idx  = idx_q;
            out_last = is_last;
            if (xfer) begin
               if (is_last) state_d = S_DONE;
               else         idx_d   = idx_q + CBITS'(1);
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Stream state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         eff_q   <= '0;
         idx_q   <= '0;
         for (int i = 0; i < int'(NCELLS); i++) snap_q[i] <= '0;
      end else begin
         state_q <= state_d;
         eff_q   <= eff_d;
         idx_q   <= idx_d;
         snap_q  <= snap_d;
      end
   end

`ifdef SORT_XCEL_DRAIN_CHECK_EN
   logic [NBITS-1:0] prev_q, prev_d;
   logic             err_q, err_d;

   // Order checker: previous drained element must not exceed the current one.
   always_comb begin
      prev_d = prev_q;
      err_d  = err_q;
      if (accept) err_d = 1'b0;
      if (xfer) begin
         prev_d = cur_data;
         if ((idx_q != '0) && (prev_q > cur_data)) err_d = 1'b1;
      end
   end

   // Checker registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q <= '0;
         err_q  <= 1'b0;
      end else begin
         prev_q <= prev_d;
         err_q  <= err_d;
      end
   end

   assign order_err = err_q;
`else
   assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_xcel_drain.sv
// Testbench for sort_xcel_drain (NBITS=32, NCELLS=8): table of drain vectors
// checked against a scoreboard queue, plus a mid-drain reset sequence.

module tb_sort_xcel_drain;

   localparam int unsigned NBITS  = 32;
   localparam int unsigned NCELLS = 8;
   localparam int unsigned CBITS  = 4;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    start_val;
   logic                    start_rdy;
   logic [NCELLS*NBITS-1:0] cells;
   logic [CBITS-1:0]        count;
   logic                    out_val;
   logic                    out_rdy;
   logic [NBITS-1:0]        out_data;
   logic [CBITS-1:0]        out_idx;
   logic                    out_last;
   logic                    done;
   logic                    order_err;

   sort_xcel_drain #(.NBITS(NBITS), .NCELLS(NCELLS)) dut (
      .clk       (clk),
      .reset     (reset),
      .start_val (start_val),
      .start_rdy (start_rdy),
      .cells     (cells),
      .count     (count),
      .out_val   (out_val),
      .out_rdy   (out_rdy),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .done      (done),
      .order_err (order_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  idx;
      logic        last;
   } exp_t;

   typedef struct {
      logic [255:0] cells;
      logic [3:0]   cnt;
      logic [7:0]   pat;
      bit           scramble;
      bit           hold;
   } vec_t;

   exp_t        exp_q[$];
   vec_t        vecs[9];
   int          n_tests = 0;
   int          n_fail  = 0;
   bit          err_m   = 1'b0;
   logic [31:0] prev_m  = '0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] err_exp();
`ifdef SORT_XCEL_DRAIN_CHECK_EN
      return 32'(err_m);
`else
      return 32'd0;
`endif
   endfunction

   function automatic logic [255:0] pack8(input logic [31:0] a0, a1, a2, a3,
                                          input logic [31:0] a4, a5, a6, a7);
      return {a7, a6, a5, a4, a3, a2, a1, a0};
   endfunction

   function automatic logic [255:0] rand_cells();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // One full drain: handshake, per-cycle compare against the queue, done timing.
   task automatic run_drain(input vec_t v);
      int   eff, cyc, w;
      bit   done_exp, finished, rdy;
      exp_t e;
      w = 0;
      while (!start_rdy && w < 20) begin
         @(negedge clk);
         w++;
      end
      check("start_rdy_before_start", 32'(start_rdy), 32'd1);
      eff = (v.cnt > 4'd8) ? 8 : int'(v.cnt);
      exp_q.delete();
      for (int i = 0; i < eff; i++) begin
         e.data = v.cells[i*32 +: 32];
         e.idx  = 4'(i);
         e.last = (i == eff - 1);
         exp_q.push_back(e);
      end
      start_val = 1'b1;
      cells     = v.cells;
      count     = v.cnt;
      out_rdy   = 1'b0;
      @(posedge clk);
      err_m = 1'b0;
      @(negedge clk);
      start_val = v.hold;
      if (v.scramble) begin
         cells = rand_cells();
         count = 4'($urandom_range(0, 15));
      end
      done_exp = (eff == 0);
      finished = 1'b0;
      cyc      = 0;
      while (!finished && cyc < 64) begin
         cyc++;
         check("done", 32'(done), 32'(done_exp));
         check("order_err", 32'(order_err), err_exp());
         if (done_exp) begin
            check("done_start_rdy", 32'(start_rdy), 32'd0);
            check("done_out_val", 32'(out_val), 32'd0);
            if (v.pat == 8'hFF) check("done_latency", 32'(cyc), 32'(eff + 1));
            finished = 1'b1;
         end else begin
            check("out_val", 32'(out_val), 32'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
               check("out_data", out_data, exp_q[0].data);
               check("out_idx", 32'(out_idx), 32'(exp_q[0].idx));
               check("out_last", 32'(out_last), 32'(exp_q[0].last));
               check("drain_start_rdy", 32'(start_rdy), 32'd0);
               rdy     = v.pat[(cyc - 1) % 8];
               out_rdy = rdy;
               if (rdy) begin
                  e = exp_q.pop_front();
                  if (e.idx != 4'd0 && prev_m > e.data) err_m = 1'b1;
                  prev_m = e.data;
                  if (e.last) done_exp = 1'b1;
               end
            end else begin
               check("idle_out_data", out_data, 32'd0);
            end
            if (v.scramble) begin
               cells = rand_cells();
               count = 4'($urandom_range(0, 15));
            end
            @(posedge clk);
            @(negedge clk);
         end
      end
      if (!finished) check("drain_timeout", 32'd0, 32'd1);
      out_rdy = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("start_rdy_after_done", 32'(start_rdy), 32'd1);
      check("no_second_done", 32'(done), 32'd0);
      check("idle_order_err", 32'(order_err), err_exp());
      start_val = 1'b0;
   endtask

   initial begin
      logic [255:0] rc;
      reset     = 1'b1;
      start_val = 1'b0;
      cells     = '0;
      count     = '0;
      out_rdy   = 1'b0;

      vecs[0] = '{pack8(3, 7, 9, 20, 0, 0, 0, 0), 4'd4, 8'hFF, 1'b0, 1'b0};
      vecs[1] = '{pack8(3, 7, 9, 20, 0, 0, 0, 0), 4'd4, 8'hE9, 1'b0, 1'b0};
      vecs[2] = '{pack8(1, 2, 3, 4, 5, 6, 7, 8), 4'd0, 8'hFF, 1'b0, 1'b0};
      vecs[3] = '{rand_cells(), 4'd12, 8'hFF, 1'b0, 1'b0};
      vecs[4] = '{pack8(11, 22, 33, 44, 55, 66, 77, 88), 4'd5, 8'hB7, 1'b1, 1'b1};
      vecs[5] = '{pack8(5, 9, 4, 12, 0, 0, 0, 0), 4'd4, 8'hFF, 1'b0, 1'b0};
      vecs[6] = '{pack8(1, 2, 4, 8, 16, 32, 64, 128), 4'd8, 8'hFF, 1'b0, 1'b0};
      vecs[7] = '{pack8(32'hFFFF_FFFF, 1, 2, 3, 4, 5, 6, 7), 4'd1, 8'h5A, 1'b0, 1'b0};
      vecs[8] = '{pack8(9, 8, 7, 6, 5, 4, 3, 2), 4'd8, 8'h6D, 1'b1, 1'b0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("rst_start_rdy", 32'(start_rdy), 32'd1);
      check("rst_out_val", 32'(out_val), 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_out_idx", 32'(out_idx), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_order_err", 32'(order_err), 32'd0);

      for (int i = 0; i < 9; i++) run_drain(vecs[i]);

      // Reset after the second transfer of a 6-element drain.
      rc        = pack8(10, 20, 30, 40, 50, 60, 0, 0);
      start_val = 1'b1;
      cells     = rc;
      count     = 4'd6;
      out_rdy   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_val = 1'b0;
      check("rst_seq_first", out_data, 32'd10);
      @(posedge clk);
      @(negedge clk);
      check("rst_seq_second", out_data, 32'd20);
      @(posedge clk);
      @(negedge clk);
      check("rst_seq_third", out_data, 32'd30);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("abort_out_val", 32'(out_val), 32'd0);
      check("abort_start_rdy", 32'(start_rdy), 32'd1);
      check("abort_out_data", out_data, 32'd0);
      check("abort_order_err", 32'(order_err), 32'd0);
      for (int i = 0; i < 8; i++) begin
         check("abort_no_done", 32'(done), 32'd0);
         check("abort_no_val", 32'(out_val), 32'd0);
         @(posedge clk);
         @(negedge clk);
      end
      out_rdy = 1'b0;
      err_m   = 1'b0;
      run_drain(vecs[0]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
